uart_apb_ctrl: RTL and testbench

UART_APB_CTRL -- requirements
Module: uart_apb_ctrl

---
 rtl/uart_apb_ctrl_if.sv | 26 ++
 rtl/uart_apb_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_apb_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_apb_ctrl_if.sv
// APB bus bundle between the UART echo controller (requester) and the UART
// register block (completer).
interface uart_apb_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              psel;
    logic              penable;
    logic [2:0]        pprot;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pprot, paddr, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pprot, paddr, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/uart_apb_ctrl.sv
// APB requester that configures a UART, then echoes every received byte back.
// Optional build macro UART_CTRL_CASE_SWAP_EN: lower-case ASCII is echoed as upper-case.
module uart_apb_ctrl #(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [31:0] BAUD_DIV = 32'd434,
    parameter logic [31:0] CTRL_VAL = 32'h0000_0003
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   en,
    uart_apb_ctrl_if.master        apb,
    output logic                   cfg_done,
    output logic                   err,
    output logic [7:0]             echo_cnt
);
    localparam logic [7:0] REG_DATA   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_CTRL   = 8'h08;
    localparam logic [7:0] REG_DIV    = 8'h0C;

    typedef enum logic [2:0] {
        S_IDLE, S_W_DIV, S_W_CTRL, S_P_RX, S_R_DATA, S_P_TX, S_W_DATA
    } state_t;

    state_t      state;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic [7:0]  req_addr;
    logic        req_write;
    logic [31:0] req_wdata;

`ifdef UART_CTRL_CASE_SWAP_EN
    assign tx_byte = (rx_byte >= 8'h61 && rx_byte <= 8'h7A) ? rx_byte - 8'h20 : rx_byte;
`else
    assign tx_byte = rx_byte;
`endif

    // Transfer the current state issues when it next starts a SETUP phase
    always_comb begin
        req_addr  = REG_DATA;
        req_write = 1'b0;
        req_wdata = 32'h0;
        case (state)
            S_IDLE, S_W_DIV: begin
                req_addr  = REG_DIV;
                req_write = 1'b1;
                req_wdata = BAUD_DIV;
            end
            S_W_CTRL: begin
                req_addr  = REG_CTRL;
                req_write = 1'b1;
                req_wdata = CTRL_VAL;
            end
            S_P_RX, S_P_TX: req_addr = REG_STATUS;
            S_R_DATA:       req_addr = REG_DATA;
            S_W_DATA: begin
                req_addr  = REG_DATA;
                req_write = 1'b1;
                req_wdata = {24'h0, tx_byte};
            end
            default: ;
        endcase
    end

    // psel low = bus idle/gap, psel & !penable = SETUP, both high = ACCESS
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            rx_byte     <= 8'h00;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pprot   <= 3'b000;
            apb.paddr   <= '0;
            apb.pwrite  <= 1'b0;
            apb.pwdata  <= 32'h0;
            apb.pstrb   <= 4'h0;
            cfg_done    <= 1'b0;
            err         <= 1'b0;
            echo_cnt    <= 8'h00;
        end else begin
            apb.pprot <= 3'b000;
            if (!apb.psel) begin
                if (state != S_P_RX || en) begin
                    apb.psel    <= 1'b1;
                    apb.penable <= 1'b0;
                    apb.paddr   <= ADDR_W'(req_addr);
                    apb.pwrite  <= req_write;
                    apb.pwdata  <= req_wdata;
                    apb.pstrb   <= req_write ? 4'hF : 4'h0;
                end
                if (state == S_IDLE) begin
                    state <= S_W_DIV;
                end
            end else if (!apb.penable) begin
                apb.penable <= 1'b1;
            end else if (apb.pready) begin
                apb.psel    <= 1'b0;
                apb.penable <= 1'b0;
                if (apb.pslverr) begin
                    // Config/poll transfers retry in place; data transfers drop the byte
                    err <= 1'b1;
                    if (state == S_R_DATA || state == S_W_DATA) begin
                        state <= S_P_RX;
                    end
                end else begin
                    case (state)
                        S_W_DIV:  state <= S_W_CTRL;
                        S_W_CTRL: begin
                            state    <= S_P_RX;
                            cfg_done <= 1'b1;
                        end
                        S_P_RX:   state <= apb.prdata[0] ? S_R_DATA : S_P_RX;
                        S_R_DATA: begin
                            rx_byte <= apb.prdata[7:0];
                            state   <= S_P_TX;
                        end
                        S_P_TX:   state <= apb.prdata[1] ? S_P_TX : S_W_DATA;
                        S_W_DATA: begin
                            echo_cnt <= echo_cnt + 8'd1;
                            state    <= S_P_RX;
                        end
                        default:  state <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Self-checking bench for uart_apb_ctrl: scripted and random APB completer
// responses, a transaction-level reference model and per-cycle protocol checks.
module tb_uart_apb_ctrl;
    localparam int unsigned ADDR_W = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       en = 1'b1;
    logic       cfg_done;
    logic       err;
    logic [7:0] echo_cnt;

    uart_apb_ctrl_if #(.ADDR_W(ADDR_W)) apb ();

    uart_apb_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .en       (en),
        .apb      (apb.master),
        .cfg_done (cfg_done),
        .err      (err),
        .echo_cnt (echo_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] prdata;
        logic        slverr;
        int          stall;
    } resp_t;

    typedef struct {
        logic [7:0]  addr;
        logic        write;
        logic [31:0] wdata;
        logic        slverr;
        int          acc;
    } xfer_t;

    resp_t resp_q[$];
    xfer_t xlog[$];

    int tot = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which transfer the controller owes next, plus visible counters
    typedef enum int {M_IDLE, M_DIV, M_CTRL, M_PRX, M_RDATA, M_PTX, M_WDATA} mph_t;
    mph_t       m_ph = M_IDLE;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_cnt = 8'h00;
    logic       m_err = 1'b0;
    logic       m_cfg = 1'b0;

    function automatic logic [7:0] tx_of(input logic [7:0] b);
`ifdef UART_CTRL_CASE_SWAP_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    function automatic void exp_req(output logic [7:0] a, output logic w, output logic [31:0] d);
        a = 8'h00; w = 1'b0; d = 32'h0;
        case (m_ph)
            M_DIV:   begin a = 8'h0C; w = 1'b1; d = 32'd434; end
            M_CTRL:  begin a = 8'h08; w = 1'b1; d = 32'h3; end
            M_PRX,
            M_PTX:   a = 8'h04;
            M_WDATA: begin a = 8'h00; w = 1'b1; d = {24'h0, tx_of(m_byte)}; end
            default: a = 8'h00;
        endcase
    endfunction

    function automatic void model_complete(input logic [31:0] rd, input logic slv);
        if (slv) begin
            m_err = 1'b1;
            if (m_ph == M_RDATA || m_ph == M_WDATA) m_ph = M_PRX;
        end else begin
            case (m_ph)
                M_DIV:   m_ph = M_CTRL;
                M_CTRL:  begin m_ph = M_PRX; m_cfg = 1'b1; end
                M_PRX:   m_ph = rd[0] ? M_RDATA : M_PRX;
                M_RDATA: begin m_byte = rd[7:0]; m_ph = M_PTX; end
                M_PTX:   m_ph = rd[1] ? M_PTX : M_WDATA;
                M_WDATA: begin m_cnt = 8'((int'(m_cnt) + 1) % 256); m_ph = M_PRX; end
                default: m_ph = M_IDLE;
            endcase
        end
    endfunction

    task automatic chk_setup();
        logic [7:0]  a;
        logic        w;
        logic [31:0] d;
        exp_req(a, w, d);
        chk("setup_psel", 32'(apb.psel), 32'd1);
        chk("setup_penable", 32'(apb.penable), 32'd0);
        chk("setup_paddr", 32'(apb.paddr), 32'(a));
        chk("setup_pwrite", 32'(apb.pwrite), 32'(w));
        chk("setup_pwdata", apb.pwdata, d);
        chk("setup_pstrb", 32'(apb.pstrb), w ? 32'hF : 32'h0);
    endtask

    // Values seen during the previous cycle (sampled by the DUT at the edge in between)
    logic        p_psel = 1'b0, p_pen = 1'b0, p_wr = 1'b0;
    logic [7:0]  p_addr = 8'h00;
    logic [31:0] p_wd = 32'h0;
    logic [3:0]  p_strb = 4'h0;
    logic        rst_s = 1'b0, en_s = 1'b0, rdy_s = 1'b0, slv_s = 1'b0;
    logic [31:0] rd_s = 32'h0;
    int          acc_n = 0;
    int          waitc = 0;
    bit          in_acc = 1'b0;
    resp_t       cur;

    // Compare process plus APB completer, both on the falling edge
    always @(negedge clk) begin : mon
        if (!rst_s) begin
            m_ph = M_IDLE; m_cnt = 8'h00; m_err = 1'b0; m_cfg = 1'b0; m_byte = 8'h00;
            chk("rst_psel", 32'(apb.psel), 32'd0);
            chk("rst_penable", 32'(apb.penable), 32'd0);
            chk("rst_paddr", 32'(apb.paddr), 32'd0);
            chk("rst_pwrite", 32'(apb.pwrite), 32'd0);
            chk("rst_pwdata", apb.pwdata, 32'd0);
            chk("rst_pstrb", 32'(apb.pstrb), 32'd0);
        end else if (m_ph == M_IDLE) begin
            m_ph = M_DIV;
            chk_setup();
        end else if (p_psel && (!p_pen || !rdy_s)) begin
            chk("acc_psel", 32'(apb.psel), 32'd1);
            chk("acc_penable", 32'(apb.penable), 32'd1);
            chk("acc_paddr_stable", 32'(apb.paddr), 32'(p_addr));
            chk("acc_pwrite_stable", 32'(apb.pwrite), 32'(p_wr));
            chk("acc_pwdata_stable", apb.pwdata, p_wd);
            chk("acc_pstrb_stable", 32'(apb.pstrb), 32'(p_strb));
        end else if (p_psel) begin
            xlog.push_back('{addr: p_addr, write: p_wr, wdata: p_wd, slverr: slv_s, acc: acc_n});
            model_complete(rd_s, slv_s);
            chk("gap_psel", 32'(apb.psel), 32'd0);
            chk("gap_penable", 32'(apb.penable), 32'd0);
        end else begin
            if (m_ph != M_PRX || en_s) chk_setup();
            else chk("hold_psel", 32'(apb.psel), 32'd0);
        end
        chk("pprot", 32'(apb.pprot), 32'd0);
        chk("cfg_done", 32'(cfg_done), 32'(m_cfg));
        chk("err", 32'(err), 32'(m_err));
        chk("echo_cnt", 32'(echo_cnt), 32'(m_cnt));

        if (apb.psel && !apb.penable) acc_n = 0;
        if (apb.psel && apb.penable) acc_n++;
        p_psel = apb.psel; p_pen = apb.penable; p_addr = apb.paddr;
        p_wr = apb.pwrite; p_wd = apb.pwdata; p_strb = apb.pstrb;
        rst_s = resetn; en_s = en;

        if (apb.psel && apb.penable) begin
            if (!in_acc) begin
                in_acc = 1'b1;
                if (resp_q.size() > 0) cur = resp_q.pop_front();
                else cur = '{prdata: $urandom, slverr: ($urandom_range(0, 15) == 0),
                             stall: $urandom_range(0, 3)};
                waitc = cur.stall;
            end else if (waitc > 0) begin
                waitc--;
            end
            apb.pready  = (waitc == 0);
            apb.prdata  = cur.prdata;
            apb.pslverr = cur.slverr;
        end else begin
            // Junk that the controller must ignore outside ACCESS
            in_acc      = 1'b0;
            apb.pready  = 1'($urandom_range(0, 1));
            apb.pslverr = 1'($urandom_range(0, 1));
            apb.prdata  = $urandom;
        end
        rdy_s = apb.pready; slv_s = apb.pslverr; rd_s = apb.prdata;
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (xlog.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("wait_log_reached", 32'(xlog.size() >= n), 32'd1);
    endtask

    task automatic push(input logic [31:0] rd, input logic slv, input int stall);
        resp_q.push_back('{prdata: rd, slverr: slv, stall: stall});
    endtask

    initial begin
        int          n;
        logic [31:0] exp_7a, exp_61;
        bit          found;
`ifdef UART_CTRL_CASE_SWAP_EN
        exp_7a = 32'h5A; exp_61 = 32'h41;
`else
        exp_7a = 32'h7A; exp_61 = 32'h61;
`endif
        apb.pready = 1'b0; apb.pslverr = 1'b0; apb.prdata = 32'h0;

        // Segment 1: config, plain echo, busy transmitter with stretched ACCESS, reset in W_DATA
        push(32'h0, 1'b0, 0);  push(32'h0, 1'b0, 0);
        push(32'h1, 1'b0, 0);  push(32'h41, 1'b0, 0); push(32'h0, 1'b0, 0); push(32'h0, 1'b0, 0);
        push(32'h1, 1'b0, 0);  push(32'h55, 1'b0, 0);
        push(32'h2, 1'b0, 3);  push(32'h2, 1'b0, 0);  push(32'h2, 1'b0, 0); push(32'h0, 1'b0, 0);
        push(32'h0, 1'b0, 0);
        push(32'h1, 1'b0, 0);  push(32'h7A, 1'b0, 0); push(32'h0, 1'b0, 0); push(32'h0, 1'b0, 20);

        repeat (3) tick();
        chk("reset_cfg_done", 32'(cfg_done), 32'd0);
        chk("reset_echo_cnt", 32'(echo_cnt), 32'd0);
        resetn = 1'b1;
        tick();
        chk("c1_psel", 32'(apb.psel), 32'd1);
        chk("c1_penable", 32'(apb.penable), 32'd0);
        chk("c1_paddr", 32'(apb.paddr), 32'h0C);
        chk("c1_pwdata", apb.pwdata, 32'd434);
        chk("c1_pwrite", 32'(apb.pwrite), 32'd1);
        tick();
        chk("c2_penable", 32'(apb.penable), 32'd1);
        tick();
        chk("c3_psel", 32'(apb.psel), 32'd0);
        tick();
        chk("c4_psel", 32'(apb.psel), 32'd1);
        chk("c4_paddr", 32'(apb.paddr), 32'h08);
        chk("c4_pwdata", apb.pwdata, 32'h3);
        tick();
        chk("c5_cfg_done", 32'(cfg_done), 32'd0);
        tick();
        chk("c6_cfg_done", 32'(cfg_done), 32'd1);

        wait_log(6, 200);
        chk("echo1_rdata_addr", 32'(xlog[3].addr), 32'h00);
        chk("echo1_w_addr", 32'(xlog[5].addr), 32'h00);
        chk("echo1_w_write", 32'(xlog[5].write), 32'd1);
        chk("echo1_w_data", xlog[5].wdata, 32'h41);
        chk("echo1_cnt", 32'(echo_cnt), 32'd1);

        wait_log(13, 300);
        n = 0;
        for (int i = 8; i < xlog.size() && !xlog[i].write; i++)
            if (xlog[i].addr == 8'h04) n++;
        chk("ptx_read_count", 32'(n), 32'd4);
        chk("ptx_access_cycles", 32'(xlog[8].acc), 32'd4);
        chk("echo2_w_data", xlog[12].wdata, 32'h55);
        chk("echo2_cnt", 32'(echo_cnt), 32'd2);

        wait_log(16, 300);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (apb.psel && apb.penable && apb.pwrite && apb.paddr == 8'h00) found = 1'b1;
            else tick();
        end
        chk("wdata_access_found", 32'(found), 32'd1);
        chk("echo3_pwdata", apb.pwdata, exp_7a);
        resetn = 1'b0;
        tick();
        chk("abort_psel", 32'(apb.psel), 32'd0);
        chk("abort_penable", 32'(apb.penable), 32'd0);
        chk("abort_paddr", 32'(apb.paddr), 32'd0);
        chk("abort_pwdata", apb.pwdata, 32'd0);
        chk("abort_pwrite", 32'(apb.pwrite), 32'd0);
        chk("abort_pstrb", 32'(apb.pstrb), 32'd0);
        chk("abort_pprot", 32'(apb.pprot), 32'd0);
        chk("abort_cfg_done", 32'(cfg_done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_echo_cnt", 32'(echo_cnt), 32'd0);

        // Segment 2: CTRL error retry, then 255 echoes and a lower-case byte that wraps the count
        xlog.delete();
        push(32'h0, 1'b0, 0); push(32'h0, 1'b1, 1); push(32'h0, 1'b0, 0);
        for (int i = 0; i < 255; i++) begin
            push(32'h1, 1'b0, 0); push($urandom, 1'b0, 0); push(32'h0, 1'b0, 0);
            push(32'h0, 1'b0, $urandom_range(0, 1));
        end
        push(32'h1, 1'b0, 0); push(32'h61, 1'b0, 0); push(32'h0, 1'b0, 0); push(32'h0, 1'b0, 0);
        tick();
        resetn = 1'b1;
        tick();
        chk("restart_psel", 32'(apb.psel), 32'd1);
        chk("restart_paddr", 32'(apb.paddr), 32'h0C);

        wait_log(2, 100);
        chk("ctrl_err_addr", 32'(xlog[1].addr), 32'h08);
        chk("ctrl_err_flag", 32'(xlog[1].slverr), 32'd1);
        chk("ctrl_err_err", 32'(err), 32'd1);
        chk("ctrl_err_cfg_done", 32'(cfg_done), 32'd0);
        wait_log(3, 100);
        chk("ctrl_retry_addr", 32'(xlog[2].addr), 32'h08);
        chk("ctrl_retry_cfg_done", 32'(cfg_done), 32'd1);

        wait_log(1027, 8000);
        chk("wrap_w_addr", 32'(xlog[1026].addr), 32'h00);
        chk("wrap_w_data", xlog[1026].wdata, exp_61);
        chk("wrap_echo_cnt", 32'(echo_cnt), 32'd0);
        chk("wrap_err_sticky", 32'(err), 32'd1);

        // Random phase: random responses, stalls and errors, with en toggling
        for (int i = 0; i < 3000; i++) begin
            tick();
            en = ($urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
